// File: rtl/pipefft_twid_seq_pkg.sv
// Shared definitions for the pipelined FFT twiddle path: default sizes of the
// per-stage twiddle RAM, its read latency, and where re/im sit in a RAM word.
package pipefft_twid_seq_pkg;

  localparam int PF_ADDR_W = 4;   // 16-entry twiddle RAM per stage
  localparam int PF_TW_W   = 64;  // {re, im}, 32 bits each
  localparam int PF_DW     = 32;  // complex sample, re high
  localparam int PF_RD_LAT = 2;   // address register + data register

  // Real part occupies the upper half of the twiddle word.
  function automatic int reMsb(input int twW);
    return twW - 1;
  endfunction

  function automatic int reLsb(input int twW);
    return twW / 2;
  endfunction

  // Imaginary part occupies the lower half of the twiddle word.
  function automatic int imMsb(input int twW);
    return twW / 2 - 1;
  endfunction

  function automatic int imLsb(input int twW);
    return twW - twW;
  endfunction

endpackage

// File: rtl/pipefft_delay_line.sv
// Valid-qualified shift pipeline. The valid bit always shifts so bubbles
// propagate; payload only moves forward behind a valid, so an idle stage holds
// its last sample.
module pipefft_delay_line
  import pipefft_twid_seq_pkg::*;
#(
  parameter int               WIDTH   = PF_DW,
  parameter int               DEPTH   = PF_RD_LAT,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             nGrst,
  input  logic [WIDTH-1:0] d,
  input  logic             dVld,
  output logic [WIDTH-1:0] q,
  output logic             qVld
);

  logic [DEPTH-1:0]            vld_p;
  logic [DEPTH-1:0][WIDTH-1:0] data_p;

  // Shift valid every clock; advance payload only behind a valid entry.
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      vld_p  <= '0;
      data_p <= {DEPTH{RST_VAL}};
    end else begin
      // stage 0: capture the incoming sample
      vld_p[0] <= dVld;
      if (dVld) data_p[0] <= d;
      // stages 1..DEPTH-1: carry it forward
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) data_p[i] <= data_p[i-1];
      end
    end
  end

  assign q    = data_p[DEPTH-1];
  assign qVld = vld_p[DEPTH-1];

endmodule

// File: rtl/pipefft_twid_seq.sv
// Twiddle read sequencer for one radix-2 SDF stage. Generates the twiddle RAM
// read address from the frame position and stride, and delays the sample and
// its unity flag through the RAM's registered read path so sample, twiddle and
// unity flag leave together.
module pipefft_twid_seq
  import pipefft_twid_seq_pkg::*;
#(
  parameter int ADDR_W = PF_ADDR_W,
  parameter int TW_W   = PF_TW_W,
  parameter int DW     = PF_DW,
  parameter int RD_LAT = PF_RD_LAT
) (
  input  logic                     clk,
  input  logic                     nGrst,
  input  logic [1:0]               stage,
  input  logic                     sync_clr,
  input  logic                     twid_ready,
  input  logic [DW-1:0]            din,
  input  logic                     din_valid,
  output logic [ADDR_W-1:0]        rAddr,
  input  logic [TW_W-1:0]          rD,
  output logic [DW-1:0]            dout,
  output logic signed [TW_W/2-1:0] tw_re,
  output logic signed [TW_W/2-1:0] tw_im,
  output logic                     tw_unity,
  output logic                     dout_valid,
  output logic                     err_notready
);

  localparam int CW     = ADDR_W + 1;
  localparam int RE_MSB = reMsb(TW_W);
  localparam int RE_LSB = reLsb(TW_W);
  localparam int IM_MSB = imMsb(TW_W);
  localparam int IM_LSB = imLsb(TW_W);

  // Second half of a butterfly block: bit (ADDR_W - s) of the frame count.
  function automatic logic halfBit(input logic [CW-1:0] c, input logic [1:0] s);
    return |(c & (CW'(1) << (ADDR_W - int'(s))));
  endfunction

  // Position within the half-block, scaled by the stride 2^s.
  function automatic logic [ADDR_W-1:0] twidAddr(input logic [CW-1:0] c,
                                                 input logic [1:0]    s);
    logic [CW-1:0] mask;
    logic [CW-1:0] j;
    mask = (CW'(1) << (ADDR_W - int'(s))) - CW'(1);
    j    = c & mask;
    return ADDR_W'(j << s);
  endfunction

  logic [CW-1:0]     cnt;
  logic [1:0]        sQ;
  logic [ADDR_W-1:0] addrHold;
  logic [CW-1:0]     cntEff;
  logic              halfB;
  logic              unityIn;
  logic [ADDR_W-1:0] addrNext;
  logic [DW:0]       alignedQ;
  logic signed [TW_W/2-1:0] twReHold;
  logic signed [TW_W/2-1:0] twImHold;

  // Address and unity flag for the sample on din this cycle. At cnt=0 the
  // half bit is 0 for every stride, so the stale sQ never matters there.
  always_comb begin
    cntEff   = sync_clr ? '0 : cnt;
    halfB    = halfBit(cntEff, sQ);
    addrNext = halfB ? twidAddr(cntEff, sQ) : '0;
    unityIn  = ~halfB | ~twid_ready;
    rAddr    = din_valid ? addrNext : addrHold;
  end

  // Frame counter, latched stride, held address and sticky not-ready flag.
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      cnt          <= '0;
      sQ           <= '0;
      addrHold     <= '0;
      err_notready <= 1'b0;
    end else if (din_valid) begin
      cnt      <= cntEff + CW'(1);
      addrHold <= addrNext;
      if (cntEff == '0) sQ <= stage;
      if (!twid_ready) err_notready <= 1'b1;
    end else if (sync_clr) begin
      cnt <= '0;
    end
  end

  // p0 -> p(RD_LAT): sample and unity flag ride alongside the RAM read.
  pipefft_delay_line #(
    .WIDTH  (DW + 1),
    .DEPTH  (RD_LAT),
    .RST_VAL({1'b1, {DW{1'b0}}})
  ) u_align (
    .clk  (clk),
    .nGrst(nGrst),
    .d    ({unityIn, din}),
    .dVld (din_valid),
    .q    (alignedQ),
    .qVld (dout_valid)
  );

  assign tw_unity = alignedQ[DW];
  assign dout     = alignedQ[DW-1:0];

  // Stage RD_LAT: RAM data for this sample is on rD now; pass it through while
  // valid and keep the last captured twiddle otherwise.
  always_comb begin
    tw_re = twReHold;
    tw_im = twImHold;
    if (dout_valid) begin
      tw_re = $signed(rD[RE_MSB:RE_LSB]);
      tw_im = $signed(rD[IM_MSB:IM_LSB]);
    end
  end

  // Remember the most recent valid twiddle for idle cycles.
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      twReHold <= '0;
      twImHold <= '0;
    end else if (dout_valid) begin
      twReHold <= tw_re;
      twImHold <= tw_im;
    end
  end

endmodule

// File: tb/tb_pipefft_twid_seq.sv
// Bench for the twiddle read sequencer: a two-cycle registered RAM model, a
// frame-position model computed with plain arithmetic, and one compare process
// checking address, alignment, twiddle pairing and the error flag each cycle.
module tb_pipefft_twid_seq;

  logic        clk;
  logic        nGrst;
  logic [1:0]  stage;
  logic        sync_clr;
  logic        twid_ready;
  logic [31:0] din;
  logic        din_valid;
  logic [3:0]  rAddr;
  logic [63:0] rD;
  logic [31:0] dout;
  logic [31:0] tw_re;
  logic [31:0] tw_im;
  logic        tw_unity;
  logic        dout_valid;
  logic        err_notready;

  pipefft_twid_seq dut (
    .clk         (clk),
    .nGrst       (nGrst),
    .stage       (stage),
    .sync_clr    (sync_clr),
    .twid_ready  (twid_ready),
    .din         (din),
    .din_valid   (din_valid),
    .rAddr       (rAddr),
    .rD          (rD),
    .dout        (dout),
    .tw_re       (tw_re),
    .tw_im       (tw_im),
    .tw_unity    (tw_unity),
    .dout_valid  (dout_valid),
    .err_notready(err_notready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Twiddle RAM: word k = {k, ~k}, address and data registered.
  logic [63:0] mem [16];
  logic [3:0]  ramA;
  initial begin
    for (int k = 0; k < 16; k++) mem[k] = {32'(k), ~32'(k)};
    ramA = '0;
    rD   = '0;
  end
  always @(posedge clk) begin
    ramA <= rAddr;
    rD   <= mem[ramA];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] d;
    bit          unity;
    int          addr;
    int          tag;
  } exp_t;

  exp_t        expQ[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  int          mCnt = 0;
  int          mS = 0;
  int          expRaddr = 0;
  int          errCycle = -1;
  logic [1:0]  curStage = 2'd0;
  logic [31:0] re17 = '0;
  logic [31:0] im17 = '0;
  logic        obsU100 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_rAddr"}, 64'(rAddr), 0);
    chk({tag, "_dout"}, 64'(dout), 0);
    chk({tag, "_tw_re"}, 64'(tw_re), 0);
    chk({tag, "_tw_im"}, 64'(tw_im), 0);
    chk({tag, "_tw_unity"}, 64'(tw_unity), 1);
    chk({tag, "_dout_valid"}, 64'(dout_valid), 0);
    chk({tag, "_err"}, 64'(err_notready), 0);
  endtask

  // Drive one cycle and predict its outcome from the frame position:
  // a block of 2*half samples, where half = 16 / 2^s; the second half uses
  // twiddle index (position mod half) * 2^s.
  task automatic drive(input bit v, input bit sc, input bit rdy,
                       input logic [31:0] d, input int tag);
    int n, half, addr;
    bit h;
    exp_t x;
    @(posedge clk); #1;
    din_valid  = v;
    sync_clr   = sc;
    twid_ready = rdy;
    din        = d;
    stage      = curStage;
    if (v) begin
      n = sc ? 0 : mCnt;
      if (n == 0) mS = int'(curStage);
      half = 16 / (1 << mS);
      h    = (n % (2 * half)) >= half;
      addr = h ? (((n % half) * (1 << mS)) % 16) : 0;
      x.cyc = cyc; x.d = d; x.unity = !h || !rdy; x.addr = addr; x.tag = tag;
      expQ.push_back(x);
      expRaddr = addr;
      mCnt = (n + 1) % 32;
      if (!rdy && errCycle < 0) errCycle = cyc;
    end else if (sc) begin
      mCnt = 0;
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (nGrst === 1'b1) begin
      chk("rAddr", 64'(rAddr), 64'(expRaddr));
      chk("err_notready", 64'(err_notready), 64'(errCycle >= 0 && cyc > errCycle));
      if (expQ.size() > 0 && expQ[0].cyc + 2 <= cyc) begin
        e = expQ.pop_front();
        chk("dout_valid", 64'(dout_valid), 1);
        chk("dout", 64'(dout), 64'(e.d));
        chk("tw_unity", 64'(tw_unity), 64'(e.unity));
        if (!e.unity) begin
          chk("tw_re", 64'(tw_re), 64'(mem[e.addr][63:32]));
          chk("tw_im", 64'(tw_im), 64'(mem[e.addr][31:0]));
        end
        if (e.tag == 17) begin re17 = tw_re; im17 = tw_im; end
        if (e.tag == 100) obsU100 = tw_unity;
      end else begin
        chk("dout_valid_idle", 64'(dout_valid), 0);
      end
    end
  end

  initial begin
    nGrst = 1'b0; din_valid = 1'b0; sync_clr = 1'b0; twid_ready = 1'b1;
    din = '0; stage = 2'd0;
    repeat (3) @(posedge clk);
    #2 checkReset("reset");
    @(posedge clk); #1 nGrst = 1'b1;

    // Full frame at s=0.
    curStage = 2'd0;
    for (int n = 0; n < 32; n++) begin
      drive(1'b1, 1'b0, 1'b1, 32'hA500_0000 | 32'(n), n);
      if (n == 16) begin #1 chk("lit_s0_addr16", 64'(rAddr), 0); end
      if (n == 17) begin #1 chk("lit_s0_addr17", 64'(rAddr), 1); end
    end
    repeat (3) drive(1'b0, 1'b0, 1'b1, '0, -1);
    chk("lit_s0_re17", 64'(re17), 64'h1);
    chk("lit_s0_im17", 64'(im17), 64'hFFFF_FFFE);

    // Full frame at s=2.
    curStage = 2'd2;
    for (int n = 0; n < 32; n++) begin
      drive(1'b1, 1'b0, 1'b1, 32'hB000_0000 | 32'(n), -1);
      if (n == 6)  begin #1 chk("lit_s2_addr6", 64'(rAddr), 8); end
      if (n == 13) begin #1 chk("lit_s2_addr13", 64'(rAddr), 4); end
    end

    // Random bubbles, with a stride change mid-frame.
    curStage = 2'd0;
    for (int i = 0; i < 48; i++) begin
      if (i == 20) curStage = 2'd1;
      drive($urandom_range(0, 2) != 0, 1'b0, 1'b1, $urandom, -1);
    end

    // sync_clr alone, then sync_clr together with the sample at cnt=9.
    curStage = 2'd1;
    drive(1'b0, 1'b1, 1'b1, '0, -1);
    for (int n = 0; n < 9; n++) drive(1'b1, 1'b0, 1'b1, 32'hC000_0000 | 32'(n), -1);
    drive(1'b1, 1'b1, 1'b1, 32'hC0DE_0009, -1);
    #1 chk("lit_sync_addr", 64'(rAddr), 0);
    for (int n = 1; n < 13; n++) drive(1'b1, 1'b0, 1'b1, 32'hC100_0000 | 32'(n), -1);

    // Reset with samples in flight.
    drive(1'b1, 1'b0, 1'b1, 32'hDEAD_0001, -1);
    drive(1'b1, 1'b0, 1'b1, 32'hDEAD_0002, -1);
    @(posedge clk); #1;
    nGrst = 1'b0; din_valid = 1'b0; sync_clr = 1'b0;
    expQ.delete(); mCnt = 0; mS = 0; expRaddr = 0; errCycle = -1;
    #1 checkReset("midreset");
    @(posedge clk); #2 checkReset("midreset_hold");
    nGrst = 1'b1;

    // Fresh frame from cnt=0, twiddle RAM not ready for sample 18.
    curStage = 2'd0;
    for (int n = 0; n < 22; n++)
      drive(1'b1, 1'b0, n != 18, 32'hD000_0000 | 32'(n), (n == 18) ? 100 : -1);
    repeat (4) drive(1'b0, 1'b0, 1'b1, '0, -1);
    chk("lit_notready_unity", 64'(obsU100), 1);
    chk("lit_err_sticky", 64'(err_notready), 1);
    chk("drain", 64'(expQ.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipefft_twid_seq.md
# pipefft_twid_seq

Twiddle read sequencer for one radix-2 single-delay-feedback stage of the pipelined FFT. It sits directly downstream of the stage's 16×64 twiddle RAM: it drives the RAM read address and consumes the 64-bit read word. It delay-matches the incoming sample stream through the RAM's two-cycle registered read path, so the butterfly/multiplier sees each sample, its twiddle and a unity flag on the same cycle.

## Interface
- `ADDR_W`, default 4: twiddle RAM address width (depth 2^ADDR_W).
- `TW_W`, default 64: RAM word width; real = `[TW_W-1:TW_W/2]`, imag = `[TW_W/2-1:0]`.
- `DW`, default 32: complex sample width (re/im of DW/2 each, packed re high).
- `RD_LAT`, default 2: RAM read latency in clocks (address register plus data register).
- `clk` in 1: single clock; also drives the RAM `rClk`.
- `nGrst` in 1: asynchronous, active-low reset.
- `stage` in 2: stride exponent s (0..ADDR_W-1), quasi-static; sampled only when the frame counter is 0.
- `sync_clr` in 1: restart frame count at next sample.
- `twid_ready` in 1: twiddle RAM loaded and valid (from the loader).
- `din` in DW: input sample.
- `din_valid` in 1: sample strobe.
- `rAddr` out ADDR_W: twiddle RAM read address.
- `rD` in TW_W: twiddle RAM read data.
- `dout` out DW: delay-matched sample.
- `tw_re`, `tw_im` out TW_W/2 each: twiddle for `dout`.
- `tw_unity` out 1: multiplier bypasses the twiddle (W^0 / pass-through half).
- `dout_valid` out 1: `dout`, `tw_*` and `tw_unity` are valid.
- `err_notready` out 1: sticky; a sample arrived while `twid_ready`=0.

## Operation
- Frame counter `cnt`, ADDR_W+1 bits. It advances by 1 on each accepted `din_valid` and wraps 2^(ADDR_W+1)-1 -> 0.
- `sync_clr` together with `din_valid`: that sample is taken as `cnt`=0 and the counter becomes 1. `sync_clr` alone: counter becomes 0.
- Latched stride `s_q` loads from `stage` whenever an accepted sample has `cnt`=0.
- Block half-bit h = `cnt[ADDR_W-s_q]`. Index j = `cnt` mod 2^(ADDR_W-s_q).
- h=0: `tw_unity`=1 and `rAddr` is don't-care. Hold `rAddr` at 0.
- h=1: `tw_unity`=0 and `rAddr` = (j << s_q) truncated to ADDR_W bits.
- `rAddr` updates combinationally from the counter and `din_valid`. It changes only on accepted samples, otherwise it holds.
- The RAM registers the address and the data, so `rD` corresponds to the address presented RD_LAT cycles earlier.
- `din`, `din_valid` and the unity flag pass through an RD_LAT-deep shift pipeline. Stage RD_LAT captures `rD` into `tw_re`/`tw_im` only when valid.
- `din_valid` while `twid_ready`=0: the sample still propagates, but with `tw_unity` forced to 1, and `err_notready` is set.
- `err_notready` clears only on reset.

## Timing
- Latency: `din_valid` at cycle t -> `dout_valid` at t+RD_LAT (t+2), with fully aligned outputs.
- Throughput: 1 sample per clock, no stall and no backpressure. Bubbles propagate as `dout_valid`=0.
- Reset values: `rAddr`=0, `dout`=0, `tw_re`=`tw_im`=0, `tw_unity`=1, `dout_valid`=0, `err_notready`=0, `cnt`=0, `s_q`=0.
- Reset mid-frame: the pipeline is flushed, no stale `dout_valid` appears, and the next sample is `cnt`=0.
- `stage` changes mid-frame take effect only at the next `cnt`=0.

## Structure
- Shared FFT package holds the `ADDR_W`/`TW_W` defaults, the re/im slice positions and a `RD_LAT` constant matching the RAM configuration.
- One sub-module, `pipefft_delay_line` (width, depth parameters, valid-qualified). It is used for the sample/valid/unity alignment.

## Test plan
- Reset, then 32 contiguous samples at s=0: `rAddr` is 0 for samples 0..15 with `tw_unity`=1, then 0,1,...,15 for samples 16..31. `dout_valid` lags `din_valid` by exactly 2.
- s=2 frame: in each 8-sample block, samples 4..7 give `rAddr`=0,4,8,12, and samples 0..3 give unity.
- RAM model preloaded with word k = {k, ~k}: sample 17 at s=0 yields `tw_re`=1, `tw_im`=0xFFFFFFFE on its `dout_valid`.
- Random `din_valid` gaps: `cnt`/`rAddr` advance only on valid samples, and `dout` order and twiddle pairing are preserved.
- `sync_clr` with a sample at `cnt`=9: that sample gets `tw_unity`=1 (`cnt`=0). Then assert `nGrst` low mid-frame: `dout_valid` drops immediately and the outputs take their reset values.
- `twid_ready`=0 during one sample: `err_notready`=1 and stays set, and that sample emerges with `tw_unity`=1.
